// File: rtl/mem_bus_arbiter_if.sv
// Core-side and memory-side signal bundle for the shared data-memory arbiter.
// The slave modport is the arbiter's view; master is the cores/memory side.
interface mem_bus_arbiter_if #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  logic [NUM_CORES-1:0]        core_req;
  logic [NUM_CORES-1:0]        core_we;
  logic [NUM_CORES*ADDR_W-1:0] core_addr;
  logic [NUM_CORES*DATA_W-1:0] core_wdata;
  logic [NUM_CORES-1:0]        core_ack;
  logic                        core_err;
  logic [DATA_W-1:0]           core_rdata;
  logic [NUM_CORES-1:0]        core_grant;
  logic                        mem_valid;
  logic                        mem_we;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic                        mem_ready;
  logic [DATA_W-1:0]           mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  mem_ready, mem_rdata,
    output core_ack, core_err, core_rdata, core_grant,
    output mem_valid, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output mem_ready, mem_rdata,
    input  core_ack, core_err, core_rdata, core_grant,
    input  mem_valid, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NUM_CORES cores.
// One transaction at a time: IDLE -> BUSY -> DONE, with a hang watchdog.
module mem_bus_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 64
) (
  input  logic clk,
  input  logic rst_n,
  mem_bus_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_CORES);
  localparam int CW = $clog2(TIMEOUT);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CW-1:0]     wd_cnt_q, wd_cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              sel_found;
  logic [IW-1:0]     sel_idx;
  logic [IW-1:0]     cand;

  // Scan starts at rr_ptr; index wraps naturally as NUM_CORES is 2^IW
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cand = rr_ptr_q + IW'(i);
      if (!sel_found && bus.core_req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wd_cnt_d = wd_cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          owner_d  = sel_idx;
          we_d     = bus.core_we[sel_idx];
          addr_d   = bus.core_addr[int'(sel_idx)*ADDR_W +: ADDR_W];
          wdata_d  = bus.core_wdata[int'(sel_idx)*DATA_W +: DATA_W];
          wd_cnt_d = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        wd_cnt_d = wd_cnt_q + 1'b1;
        // A late mem_ready still beats the watchdog on the same cycle
        if (bus.mem_ready) begin
          rdata_d = we_q ? '0 : bus.mem_rdata;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (wd_cnt_q == CW'(TIMEOUT-1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        rr_ptr_d = owner_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wd_cnt_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wd_cnt_q <= wd_cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  logic                 busy;
  logic                 done;
  logic [NUM_CORES-1:0] owner_oh;

  assign busy     = (state_q == BUSY);
  assign done     = (state_q == DONE);
  assign owner_oh = NUM_CORES'(1) << owner_q;

  assign bus.mem_valid  = busy;
  assign bus.mem_we     = busy & we_q;
  assign bus.mem_addr   = busy ? addr_q : '0;
  assign bus.mem_wdata  = busy ? wdata_q : '0;
  assign bus.core_grant = (busy | done) ? owner_oh : '0;
  assign bus.core_ack   = done ? owner_oh : '0;
  assign bus.core_rdata = done ? rdata_q : '0;
  assign bus.core_err   = done & err_q;
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one data-memory port among the NUM_CORES cores of multicore_processor.
- Sits between each core's memory stage and the shared data memory.
- Accepts one request at a time, drives a valid/ready transaction to memory, and returns read data plus a one-cycle ack to the owning core.
- A watchdog aborts memory transactions that hang.

Parameters:
NUM_CORES, 4, number of requesting cores (power of two, 2..8)
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 64, max BUSY cycles waiting for mem_ready before abort (>=2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
core_req  in  NUM_CORES  per-core request; held high with fields stable until ack
core_we  in  NUM_CORES  per-core write enable (1=store, 0=load)
core_addr  in  NUM_CORES*ADDR_W  packed addresses, core i at [i*ADDR_W +: ADDR_W]
core_wdata  in  NUM_CORES*DATA_W  packed store data
core_ack  out  NUM_CORES  one-hot, one-cycle completion pulse
core_err  out  1  high with core_ack when transaction timed out
core_rdata  out  DATA_W  load data, broadcast, valid only while core_ack is high
core_grant  out  NUM_CORES  one-hot owner of the bus during BUSY/DONE
mem_valid  out  1  memory request valid
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ready  in  1  memory completion; mem_rdata valid in same cycle
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset, async on rst_n=0:
  - state=IDLE, rr_ptr=0, owner=0, wd_cnt=0.
  - All outputs 0.
  - Any in-flight memory transaction is abandoned; no ack is issued.
- All outputs are registered or decoded from state registers. No combinational path from core_req or mem_ready to any output.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If core_req is nonzero, select the first asserted index scanning rr_ptr, rr_ptr+1, ... (mod NUM_CORES).
  - Latch owner, we, addr and wdata of the selected core; clear wd_cnt; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Outputs: mem_valid=1, mem_we/addr/wdata from the latched registers (stable for the whole state), core_grant=onehot(owner).
  - wd_cnt increments each cycle.
  - On mem_ready=1: latch rdata_q = we ? 0 : mem_rdata, err_q=0, go to DONE.
  - Else if wd_cnt == TIMEOUT-1: rdata_q=0, err_q=1, go to DONE.
  - If mem_ready and timeout coincide, mem_ready wins (err_q=0).
- DONE:
  - Outputs: core_ack[owner]=1, core_rdata=rdata_q, core_err=err_q, core_grant held, mem_valid=0.
  - rr_ptr <= (owner+1) mod NUM_CORES; go to IDLE.
- Latency: request first seen in IDLE at edge N gives mem_valid from N+1. mem_ready in the first BUSY cycle gives ack in cycle N+2. Back-to-back service period is 3 cycles minimum (IDLE, BUSY, DONE).
- Core deasserts req before selection: it is ignored. Core deasserts req after selection: the transaction still completes and ack is still pulsed.
- Fairness: a continuously requesting core is served within NUM_CORES transactions. A core just acked has lowest priority in the next arbitration.
- Only one outstanding memory transaction at any time. mem_ready outside BUSY is ignored.
- Invariant: core_ack and core_grant are zero or one-hot, and core_ack is a subset of core_grant.

Test Plan:
- Reset: rst_n=0 mid-BUSY with core 2 owning → all outputs 0 immediately (asynchronously). After release with core_req=0001, core 0 is granted, not core 2.
- Single load: core1 req, we=0, addr=0x40. Memory returns mem_ready one cycle after mem_valid with rdata 0xDEADBEEF → core_ack=0010 and core_rdata=0xDEADBEEF at req edge+3. mem_addr=0x40 throughout BUSY.
- Round robin: all four cores hold req, single-cycle memory → acks in order 0,1,2,3,0 with 3 cycles between acks. Then drop core1 → order 2,3,0,2.
- Store: core3 we=1, addr=0x100, wdata=0x12345678 → mem_we=1, mem_wdata=0x12345678; ack has core_rdata=0, core_err=0.
- Timeout: mem_ready held 0 with TIMEOUT=64 → mem_valid high exactly 64 cycles, then core_ack with core_err=1 and rdata=0. The next requester is then served normally.
- Boundary: mem_ready asserted in the same cycle wd_cnt reaches TIMEOUT-1 → core_err=0 and the data is delivered. mem_ready pulsed while IDLE → no ack, no state change.
